// File: rtl/tdm_one_four_demux.sv
// One-to-four TDM demultiplexer with frame sync tracking.
// Slots 0..2 are shadowed; slot 3 completes the frame into y0..y3.
module tdm_one_four_demux #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [WIDTH-1:0] din,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             valid,
    output logic             sync_err
);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       slot_q;
    logic [1:0]       slot_d;
    logic [WIDTH-1:0] sh0;
    logic [WIDTH-1:0] sh1;
    logic [WIDTH-1:0] sh2;

    logic store0;
    logic store_mid;
    logic frame_done;
    logic err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) state_d = LOCKED;
                end
                LOCKED: begin
                    if (!sync && slot_q == 2'd0) state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Per-sample actions and slot update
    always_comb begin
        slot_d     = slot_q;
        store0     = 1'b0;
        store_mid  = 1'b0;
        frame_done = 1'b0;
        err        = 1'b0;
        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        store0 = 1'b1;
                        slot_d = 2'd1;
                    end else begin
                        slot_d = 2'd0;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // early sync restarts the frame from this sample
                        store0 = 1'b1;
                        slot_d = 2'd1;
                        err    = (slot_q != 2'd0);
                    end else if (slot_q == 2'd0) begin
                        err    = 1'b1;
                        slot_d = 2'd0;
                    end else if (slot_q == 2'd3) begin
                        frame_done = 1'b1;
                        slot_d     = 2'd0;
                    end else begin
                        store_mid = 1'b1;
                        slot_d    = slot_q + 2'd1;
                    end
                end
                default: slot_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= 2'd0;
            sh0      <= '0;
            sh1      <= '0;
            sh2      <= '0;
            y0       <= '0;
            y1       <= '0;
            y2       <= '0;
            y3       <= '0;
            valid    <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            valid    <= frame_done;
            sync_err <= err;
            if (store0) sh0 <= din;
            if (store_mid && slot_q == 2'd1) sh1 <= din;
            if (store_mid && slot_q == 2'd2) sh2 <= din;
            if (frame_done) begin
                y0 <= sh0;
                y1 <= sh1;
                y2 <= sh2;
                y3 <= din;
            end
        end
    end

    assign s1 = slot_q[1];
    assign s0 = slot_q[0];

endmodule

// File: tb/tb_tdm_one_four_demux.sv
// Randomized and directed bench for tdm_one_four_demux (WIDTH=4)
// against a queue-based frame model.
module tb_tdm_one_four_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sync;
    logic [3:0] din;
    logic       s1;
    logic       s0;
    logic [3:0] y0;
    logic [3:0] y1;
    logic [3:0] y2;
    logic [3:0] y3;
    logic       valid;
    logic       sync_err;

    int tests = 0;
    int fails = 0;

    tdm_one_four_demux #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .din      (din),
        .s1       (s1),
        .s0       (s0),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .valid    (valid),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    // Model: a locked flag and the samples gathered so far in the frame
    logic [3:0] mq[$];
    logic [3:0] m_y[4];
    logic       m_locked;
    logic       m_valid;
    logic       m_err;
    int         n_valid;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic sy,
                         input logic [3:0] d);
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (r) begin
            mq.delete();
            m_locked = 1'b0;
            for (int i = 0; i < 4; i++) m_y[i] = 4'h0;
        end else if (e) begin
            if (!m_locked) begin
                if (sy) begin
                    m_locked = 1'b1;
                    mq = {d};
                end
            end else if (sy) begin
                m_err = (mq.size() != 0);
                mq = {d};
            end else if (mq.size() == 0) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
            end else begin
                mq.push_back(d);
                if (mq.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_y[i] = mq[i];
                    m_valid = 1'b1;
                    mq.delete();
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic sy,
                        input logic [3:0] d, input string tag);
        @(negedge clk);
        rst  = r;
        en   = e;
        sync = sy;
        din  = d;
        @(posedge clk);
        model(r, e, sy, d);
        #1;
        if (valid) n_valid++;
        chk({tag, "_y0"}, y0, m_y[0]);
        chk({tag, "_y1"}, y1, m_y[1]);
        chk({tag, "_y2"}, y2, m_y[2]);
        chk({tag, "_y3"}, y3, m_y[3]);
        chk({tag, "_valid"}, valid, m_valid);
        chk({tag, "_err"}, sync_err, m_err);
        chk({tag, "_slot"}, {s1, s0}, mq.size());
        chk({tag, "_excl"}, valid & sync_err, 0);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, tag);
    endtask

    initial begin
        int pos;
        logic [3:0] fr[4];
        rst = 1'b1; en = 1'b0; sync = 1'b0; din = 4'h0;
        m_locked = 1'b0; n_valid = 0;
        for (int i = 0; i < 4; i++) m_y[i] = 4'h0;

        step(1'b1, 1'b1, 1'b1, 4'hF, "reset");
        chk("reset_y0_zero", y0, 0);

        // Basic frame
        fr = '{4'h3, 4'h5, 4'h9, 4'hC};
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i == 0, fr[i], "basic");
        chk("basic_y3", y3, 4'hC);
        chk("basic_valid", valid, 1);
        idle(1, "basic_after");

        // Same frame with stalls between samples
        step(1'b1, 1'b0, 1'b0, 4'h0, "rst2");
        n_valid = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, i == 0, fr[i], "stall");
            idle(2, "stall_idle");
        end
        chk("stall_one_valid", n_valid, 1);

        // Early sync discards 1,2
        step(1'b0, 1'b1, 1'b1, 4'h1, "early");
        step(1'b0, 1'b1, 1'b0, 4'h2, "early");
        step(1'b0, 1'b1, 1'b1, 4'h7, "early_sync");
        chk("early_err", sync_err, 1);
        step(1'b0, 1'b1, 1'b0, 4'h8, "early");
        step(1'b0, 1'b1, 1'b0, 4'h9, "early");
        step(1'b0, 1'b1, 1'b0, 4'hA, "early");
        chk("early_y0", y0, 4'h7);

        // Missing sync drops to hunt
        step(1'b0, 1'b1, 1'b0, 4'h4, "miss");
        chk("miss_err", sync_err, 1);
        n_valid = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 4'(i), "hunt");
        chk("hunt_no_valid", n_valid, 0);

        // Two back-to-back frames
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, (i % 4) == 0, 4'(i + 3), "b2b");
        chk("b2b_y3", y3, 4'hA);

        // Reset mid-frame
        step(1'b0, 1'b1, 1'b1, 4'hE, "mid");
        step(1'b0, 1'b1, 1'b0, 4'hD, "mid");
        step(1'b1, 1'b1, 1'b0, 4'hB, "mid_rst");
        chk("mid_y0", y0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'h6, "mid_hunt");

        // Randomized traffic, mostly well-framed
        pos = 0;
        for (int i = 0; i < 3000; i++) begin
            logic r, e, sy;
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 3) != 0);
            sy = (pos == 0);
            if ($urandom_range(0, 19) == 0) sy = ~sy;
            step(r, e, sy, 4'($urandom), "rand");
            if (e && !r) pos = (pos + 1) % 4;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
